// File: rtl/noc_params.sv
// Shared NoC types: flit format, routing ports and input-buffer FSM states.
// Also holds small label-classification helpers used by the input buffer.
package noc_params;

  localparam int VC_NUM         = 4;
  localparam int VC_SIZE        = $clog2(VC_NUM);
  localparam int FLIT_DATA_SIZE = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;

  typedef struct packed {
    flit_label_t               flit_label;
    logic [VC_SIZE-1:0]        vc_id;
    logic [FLIT_DATA_SIZE-1:0] data;
  } flit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VA   = 2'd1,
    SA   = 2'd2
  } input_block_state_t;

  function automatic logic is_head_label(input flit_label_t label);
    return (label == HEAD) || (label == HEADTAIL);
  endfunction

  function automatic logic is_tail_label(input flit_label_t label);
    return (label == TAIL) || (label == HEADTAIL);
  endfunction

endpackage

// File: rtl/circular_buffer.sv
// Flit FIFO with wrap-around pointers, full/empty flags and on/off credit signal.
// A write while full is performed only when a read happens in the same cycle.
module circular_buffer
  import noc_params::*;
#(
  parameter int BUFFER_SIZE    = 8,
  parameter int PIPELINE_DEPTH = 5
) (
  input  logic  clk,
  input  logic  rst,
  input  flit_t data_i,
  input  logic  read_i,
  input  logic  write_i,
  output flit_t data_o,
  output logic  is_full_o,
  output logic  is_empty_o,
  output logic  on_off_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam logic [PTR_W:0] DEPTH_CNT = BUFFER_SIZE[PTR_W:0];
  localparam logic [PTR_W:0] THRESH    = PIPELINE_DEPTH[PTR_W:0];

  flit_t          r_mem [BUFFER_SIZE];
  logic [PTR_W:0] r_rd_ptr;
  logic [PTR_W:0] r_wr_ptr;

  logic [PTR_W:0] w_count;
  logic [PTR_W:0] w_free;
  logic           w_do_read;
  logic           w_do_write;

  // The extra pointer MSB distinguishes full from empty when indices match.
  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_free     = DEPTH_CNT - w_count;
  assign is_empty_o = (w_count == '0);
  assign is_full_o  = (w_count == DEPTH_CNT);
  assign on_off_o   = (w_free > THRESH);

  assign w_do_read  = read_i && !is_empty_o;
  assign w_do_write = write_i && (!is_full_o || w_do_read);

  assign data_o = is_empty_o ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_do_read)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_write) r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_write) r_mem[r_wr_ptr[PTR_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/input_buffer.sv
// Per-VC router input buffer: tracks each packet through IDLE -> VA -> SA,
// latches route and downstream VC, and flags protocol violations.
module input_buffer
  import noc_params::*;
#(
  parameter int BUFFER_SIZE    = 8,
  parameter int PIPELINE_DEPTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  flit_t              data_i,
  input  logic               write_i,
  input  logic               read_i,
  input  port_t              out_port_i,
  input  logic [VC_SIZE-1:0] vc_new_i,
  input  logic               vc_valid_i,
  output flit_t              data_o,
  output port_t              out_port_o,
  output logic               vc_request_o,
  output logic               switch_request_o,
  output logic               vc_allocatable_o,
  output logic               is_full_o,
  output logic               is_empty_o,
  output logic               on_off_o,
  output logic               error_o,
  output input_block_state_t state_o
);

  input_block_state_t r_state;
  port_t              r_out_port;
  logic [VC_SIZE-1:0] r_vc;
  logic               r_error;
  logic               r_vc_alloc;

  input_block_state_t w_next_state;
  port_t              w_next_out_port;
  logic [VC_SIZE-1:0] w_next_vc;
  logic               w_read_ok;
  logic               w_write_ok;
  logic               w_proto_ok;
  logic               w_room;
  logic               w_pop_tail;
  logic               w_in_head;
  logic               w_error;
  logic               w_vc_alloc;
  flit_t              w_fifo_data;
  logic               w_full;
  logic               w_empty;

  circular_buffer #(
    .BUFFER_SIZE    (BUFFER_SIZE),
    .PIPELINE_DEPTH (PIPELINE_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .read_i     (w_read_ok),
    .write_i    (w_write_ok),
    .data_o     (w_fifo_data),
    .is_full_o  (w_full),
    .is_empty_o (w_empty),
    .on_off_o   (on_off_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_out_port <= LOCAL;
      r_vc       <= '0;
      r_error    <= 1'b0;
      r_vc_alloc <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_out_port <= w_next_out_port;
      r_vc       <= w_next_vc;
      r_error    <= w_error;
      r_vc_alloc <= w_vc_alloc;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_next_out_port = r_out_port;
    w_next_vc       = r_vc;
    w_vc_alloc      = 1'b0;
    w_proto_ok      = 1'b0;

    w_in_head  = is_head_label(data_i.flit_label);
    w_read_ok  = read_i && (r_state == SA) && !w_empty;
    w_pop_tail = w_read_ok && is_tail_label(w_fifo_data.flit_label);
    w_room     = !w_full || w_read_ok;

    // A head may only follow a tail that leaves the buffer in the same cycle.
    case (r_state)
      IDLE:    w_proto_ok = w_in_head;
      VA:      w_proto_ok = !w_in_head;
      SA:      w_proto_ok = !w_in_head || w_pop_tail;
      default: w_proto_ok = 1'b0;
    endcase

    w_write_ok = write_i && w_proto_ok && w_room;
    w_error    = (write_i && !w_write_ok) || (read_i && !w_read_ok);

    case (r_state)
      IDLE: begin
        if (w_write_ok) begin
          w_next_state    = VA;
          w_next_out_port = out_port_i;
        end
      end
      VA: begin
        if (vc_valid_i) begin
          w_next_state = SA;
          w_next_vc    = vc_new_i;
        end
      end
      SA: begin
        if (w_pop_tail) begin
          w_vc_alloc = 1'b1;
          if (w_write_ok && w_in_head) begin
            w_next_state    = VA;
            w_next_out_port = out_port_i;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    data_o = w_fifo_data;
    if (!w_empty) data_o.vc_id = r_vc;
  end

  assign out_port_o       = r_out_port;
  assign vc_request_o     = (r_state == VA);
  assign switch_request_o = (r_state == SA) && !w_empty;
  assign vc_allocatable_o = r_vc_alloc;
  assign error_o          = r_error;
  assign is_full_o        = w_full;
  assign is_empty_o       = w_empty;
  assign state_o          = r_state;

endmodule

// File: doc/input_buffer.md
# input_buffer

Per-virtual-channel input buffer of the router input port, sitting directly downstream of the link and wrapping one `circular_buffer` FIFO instance. It tracks each packet through a three-state pipeline FSM: idle, virtual-channel allocation (VA), then switch allocation (SA). It latches the route for each head flit and rewrites the outgoing flit's `vc_id` with the allocated downstream VC. It drives request lines toward the VC and switch allocators, and flags protocol errors.

## Interface
- `BUFFER_SIZE`, 8: FIFO depth in flits; power of two, ≥ 2.
- `PIPELINE_DEPTH`, 5: router pipeline depth, passed to `circular_buffer` for on/off flow-control threshold.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `data_i` in `flit_t`: incoming flit.
- `write_i` in 1: push `data_i` this cycle.
- `read_i` in 1: pop front flit (switch allocator grant).
- `out_port_i` in `port_t`: route computed combinationally from `data_i` head destination.
- `vc_new_i` in `VC_SIZE`: downstream VC granted by the VC allocator.
- `vc_valid_i` in 1: `vc_new_i` is valid (VA grant).
- `data_o` out `flit_t`: front flit, with `vc_id` replaced by the latched downstream VC.
- `out_port_o` out `port_t`: latched route of the current packet.
- `vc_request_o` out 1: high in VA.
- `switch_request_o` out 1: high in SA while not empty.
- `vc_allocatable_o` out 1: one-cycle pulse when a tail leaves the buffer (the upstream VC is free).
- `is_full_o`, `is_empty_o`, `on_off_o` out 1: passed through from `circular_buffer`.
- `error_o` out 1: registered one-cycle pulse on a protocol violation.

## Operation
- States: IDLE, VA, SA.
- **IDLE**
  - `write_i` with label HEAD or HEADTAIL: push the flit, latch `out_port_i` into `out_port_o`, go to VA.
  - `write_i` with label BODY or TAIL: drop the flit and pulse `error_o`.
- **VA**
  - `vc_request_o` = 1.
  - On `vc_valid_i`: latch `vc_new_i` and go to SA.
  - BODY or TAIL writes are accepted.
  - HEAD or HEADTAIL write (packet interleave): drop and pulse `error_o`.
- **SA**
  - `switch_request_o` = `~is_empty_o`.
  - `read_i` pops the front flit.
  - Popping a TAIL or HEADTAIL:
    - pulse `vc_allocatable_o`;
    - go to IDLE, unless a HEAD or HEADTAIL is written in the same cycle, in which case latch the new route and go to VA.
  - Any other HEAD write: drop and pulse `error_o`.
- `read_i` outside SA, or while empty: ignored and pulses `error_o`.
- `write_i` while full, without a simultaneous accepted read: dropped and pulses `error_o`.
- Full with simultaneous read and write in SA: both are performed; occupancy is unchanged.
- `data_o.vc_id` = latched downstream VC. All other `data_o` fields equal the stored flit. `data_o` = '0 when empty.
- Pointers wrap modulo `BUFFER_SIZE`.
- `on_off_o` = 1 iff free slots > `PIPELINE_DEPTH`. With the defaults, it is off once occupancy ≥ 3.

## Timing
- Reset (asynchronous, held while `rst`=1):
  - state IDLE, FIFO empty;
  - `data_o`='0, `out_port_o`='0, latched VC=0;
  - `vc_request_o`=0, `switch_request_o`=0, `vc_allocatable_o`=0, `error_o`=0;
  - `is_full_o`=0, `is_empty_o`=1, `on_off_o`=1.
- Reset asserted mid-packet discards all contents and returns to IDLE with no error pulse.
- Write at edge k: flit visible on `data_o` and `is_empty_o`=0 after edge k (1-cycle latency).
- VA entry: `vc_request_o` rises the cycle after the head write edge.
- VA grant: `vc_valid_i` sampled at edge k moves to SA after edge k; `switch_request_o` is high from that cycle if not empty.
- Read at edge k: next flit (or '0) on `data_o` after edge k.
- `vc_allocatable_o` and `error_o` are registered: they are high for the cycle after the causing edge.
- All state changes occur on the `clk` rising edge only.

## Structure
- `noc_params` package holds:
  - existing: `flit_t`, `flit_label_t` (HEAD, BODY, TAIL, HEADTAIL), `port_t`, `VC_SIZE`;
  - new: `input_block_state_t` {IDLE, VA, SA}.
- Sub-module: `circular_buffer` (storage, pointers, full/empty, on/off).
- `input_buffer` contains only the FSM, the route and VC registers, and the gating of `read_i`/`write_i` into the FIFO.

## Test plan
- **Single packet:** HEAD, BODY, TAIL with `out_port_i`=EAST; `vc_valid_i` with `vc_new_i`=2 two cycles after the head.
  - `vc_request_o` is high for exactly 2 cycles; SA is entered.
  - Three reads yield the flits in order with `vc_id`=2 and `out_port_o`=EAST.
  - `vc_allocatable_o` pulses once after the TAIL read; state returns to IDLE.
- **Fill and drain:** write 8 flits (HEAD plus 7 BODY).
  - `on_off_o` falls after the 3rd write; `is_full_o` rises after the 8th.
  - A 9th write is dropped and pulses `error_o`.
  - In SA, 8 reads empty the FIFO; a 9th read pulses `error_o` and `data_o`='0.
- **Simultaneous read/write:** full in SA, read plus write of a BODY together → occupancy stays 8, FIFO order is preserved across pointer wrap, and no error.
- **Back-to-back packets:** HEADTAIL read in the same cycle as a new HEAD write → `vc_allocatable_o` pulses and the state goes straight to VA with the new route latched.
- **Protocol errors:**
  - BODY written in IDLE → dropped, `error_o` pulses, `is_empty_o` stays 1.
  - HEAD written in VA → dropped, `error_o` pulses.
  - `read_i` in VA → ignored, `error_o` pulses.
- **Async reset mid-packet:** `rst` asserted between clock edges while in SA with 3 flits stored → outputs immediately take their reset values; after release, a fresh HEAD is accepted normally.
